// File: rtl/pong_engine2p.sv
// +----------------------------------------------------------------------------+
// | Module      : pong_engine2p                                                |
// | Description : Two-player pong game engine. Holds ball, paddle, score and   |
// |               match state, advances the game once every FRAME_DIV vsync    |
// |               frames, and renders the playfield to 1-bit colour video      |
// |               with one char_clock of latency.                              |
// |               Optional macro PONG_CPU_PLAYER_EN: right paddle tracks the   |
// |               ball automatically and key_r is ignored.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pong_engine2p #(
  parameter int FIELD_W     = 66,
  parameter int FIELD_H     = 37,
  parameter int CX_SHIFT    = 1,
  parameter int CY_SHIFT    = 4,
  parameter int PAD_H       = 6,
  parameter int FRAME_DIV   = 3,
  parameter int WIN_SCORE   = 7,
  parameter int PAUSE_STEPS = 20
) (
  input  logic        char_clock,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [1:0]  key_l,
  input  logic [1:0]  key_r,
  input  logic        key_start_n,
  input  logic [7:0]  char_count,
  input  logic [11:0] line_count,
  input  logic        pre_visible,
  output logic        video,
  output logic        video_r,
  output logic        video_g,
  output logic        video_b,
  output logic [7:0]  score_l,
  output logic [7:0]  score_r,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_POINT    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam int         c_DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(FRAME_DIV - 1);

  localparam logic [7:0] c_BALL_X0   = 8'(FIELD_W / 2);
  localparam logic [7:0] c_BALL_Y0   = 8'(FIELD_H / 2);
  localparam logic [7:0] c_PAD_Y0    = 8'((FIELD_H - PAD_H) / 2);
  localparam logic [7:0] c_PAD_MAX   = 8'(FIELD_H - 1 - PAD_H);
  localparam logic [7:0] c_PAD_SPAN  = 8'(PAD_H - 1);
  localparam logic [7:0] c_PAD_HALF  = 8'(PAD_H / 2);
  localparam logic [7:0] c_Y_MAX     = 8'(FIELD_H - 2);
  localparam logic [7:0] c_HIT_L     = 8'd3;
  localparam logic [7:0] c_HIT_R     = 8'(FIELD_W - 4);
  localparam logic [7:0] c_GOAL_R    = 8'(FIELD_W - 1);
  localparam logic [7:0] c_WIN       = 8'(WIN_SCORE);
  localparam logic [7:0] c_PAUSE_MAX = 8'(PAUSE_STEPS - 1);

  localparam logic [11:0] c_FW12     = 12'(FIELD_W);
  localparam logic [11:0] c_FH12     = 12'(FIELD_H);
  localparam logic [11:0] c_PADL_X12 = 12'd2;
  localparam logic [11:0] c_PADR_X12 = 12'(FIELD_W - 3);
  localparam logic [11:0] c_SPAN12   = 12'(PAD_H - 1);

  // Paddle top-row update: up wins over down, clamped inside the walls.
  function automatic logic [7:0] f_pad_next(input logic [7:0] top,
                                            input logic up, input logic dn);
    logic [7:0] nxt;
    nxt = top;
    if (up) begin
      if (top > 8'd1) nxt = top - 8'd1;
    end else if (dn) begin
      if (top < c_PAD_MAX) nxt = top + 8'd1;
    end
    return nxt;
  endfunction

  logic                r_vs_s1, r_vs_s2, r_vs_s3;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_start_req;
  logic [2:0]          r_state;
  logic [7:0]          r_ball_x, r_ball_y;
  logic                r_dx_neg, r_dy_neg, r_serve_neg;
  logic [7:0]          r_pad_l, r_pad_r;
  logic [7:0]          r_score_l, r_score_r;
  logic                r_game_over, r_winner;
  logic [7:0]          r_pause;
  logic                r_video, r_video_r, r_video_g, r_video_b;

  logic                w_edge, w_step, w_start;
  logic                w_r_up, w_r_dn;
  logic [7:0]          w_pad_l_n, w_pad_r_n;
  logic                w_wall, w_hit_l, w_hit_r;
  logic                w_dx_neg_n, w_dy_neg_n;
  logic [7:0]          w_bx_n, w_by_n;
  logic [7:0]          w_sl_inc, w_sr_inc;

  assign w_edge  = r_vs_s2 & ~r_vs_s3;
  assign w_step  = w_edge && (r_div_cnt == c_DIV_MAX);
  assign w_start = r_start_req | ~key_start_n;

`ifdef PONG_CPU_PLAYER_EN
  logic w_unused_key_r;
  assign w_unused_key_r = ^key_r;
  assign w_r_up = (r_pad_r + c_PAD_HALF) > r_ball_y;
  assign w_r_dn = (r_pad_r + c_PAD_HALF) < r_ball_y;
`else
  assign w_r_up = ~key_r[0];
  assign w_r_dn = ~key_r[1];
`endif

  assign w_pad_l_n = f_pad_next(r_pad_l, ~key_l[0], ~key_l[1]);
  assign w_pad_r_n = f_pad_next(r_pad_r, w_r_up, w_r_dn);

  // Ball physics use the paddle positions from before this step.
  assign w_wall  = (r_ball_y == 8'd1 && r_dy_neg) || (r_ball_y == c_Y_MAX && !r_dy_neg);
  assign w_hit_l = r_dx_neg && (r_ball_x == c_HIT_L) &&
                   (r_ball_y >= r_pad_l) && (r_ball_y <= r_pad_l + c_PAD_SPAN);
  assign w_hit_r = !r_dx_neg && (r_ball_x == c_HIT_R) &&
                   (r_ball_y >= r_pad_r) && (r_ball_y <= r_pad_r + c_PAD_SPAN);
  assign w_dx_neg_n = r_dx_neg ^ (w_hit_l | w_hit_r);
  assign w_dy_neg_n = r_dy_neg ^ w_wall;
  assign w_bx_n = w_dx_neg_n ? r_ball_x - 8'd1 : r_ball_x + 8'd1;
  assign w_by_n = w_dy_neg_n ? r_ball_y - 8'd1 : r_ball_y + 8'd1;

  assign w_sl_inc = (r_score_l == 8'hFF) ? 8'hFF : r_score_l + 8'd1;
  assign w_sr_inc = (r_score_r == 8'hFF) ? 8'hFF : r_score_r + 8'd1;

  // vsync synchroniser, edge history and frame divider.
  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_s3   <= 1'b0;
      r_div_cnt <= '0;
    end else begin
      r_vs_s1 <= vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_s3 <= r_vs_s2;
      if (w_edge) r_div_cnt <= (r_div_cnt == c_DIV_MAX) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Start button is remembered from any cycle until the next game step.
  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n)          r_start_req <= 1'b0;
    else if (w_step)       r_start_req <= 1'b0;
    else if (!key_start_n) r_start_req <= 1'b1;
  end

  // Match state machine, ball, paddles and scores; advances on game steps only.
  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ball_x    <= c_BALL_X0;
      r_ball_y    <= c_BALL_Y0;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
      r_serve_neg <= 1'b0;
      r_pad_l     <= c_PAD_Y0;
      r_pad_r     <= c_PAD_Y0;
      r_score_l   <= 8'd0;
      r_score_r   <= 8'd0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_pause     <= 8'd0;
    end else if (w_step) begin
      if (r_state != ST_GAMEOVER) begin
        r_pad_l <= w_pad_l_n;
        r_pad_r <= w_pad_r_n;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_SERVE;
        end
        ST_SERVE: begin
          r_ball_x <= c_BALL_X0;
          r_ball_y <= c_BALL_Y0;
          r_dx_neg <= r_serve_neg;
          r_dy_neg <= 1'b0;
          r_state  <= ST_PLAY;
        end
        ST_PLAY: begin
          r_ball_x <= w_bx_n;
          r_ball_y <= w_by_n;
          r_dx_neg <= w_dx_neg_n;
          r_dy_neg <= w_dy_neg_n;
          if (w_bx_n == 8'd0) begin
            // Left side conceded: right scores, next serve heads left.
            r_score_r   <= w_sr_inc;
            r_serve_neg <= 1'b1;
            r_pause     <= 8'd0;
            if (w_sr_inc == c_WIN) begin
              r_state     <= ST_GAMEOVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b1;
            end else begin
              r_state <= ST_POINT;
            end
          end else if (w_bx_n == c_GOAL_R) begin
            r_score_l   <= w_sl_inc;
            r_serve_neg <= 1'b0;
            r_pause     <= 8'd0;
            if (w_sl_inc == c_WIN) begin
              r_state     <= ST_GAMEOVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b0;
            end else begin
              r_state <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (r_pause == c_PAUSE_MAX) r_state <= ST_SERVE;
          else                        r_pause <= r_pause + 8'd1;
        end
        ST_GAMEOVER: begin
          if (w_start) begin
            r_score_l   <= 8'd0;
            r_score_r   <= 8'd0;
            r_game_over <= 1'b0;
            r_state     <= ST_SERVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [7:0]  w_cx;
  logic [11:0] w_cx12, w_cy12, w_bx12, w_by12, w_pl12, w_pr12;
  logic        w_in_field, w_border, w_paddle, w_ball, w_fg;

  assign w_cx   = char_count >> CX_SHIFT;
  assign w_cx12 = {4'd0, w_cx};
  assign w_cy12 = line_count >> CY_SHIFT;
  assign w_bx12 = {4'd0, r_ball_x};
  assign w_by12 = {4'd0, r_ball_y};
  assign w_pl12 = {4'd0, r_pad_l};
  assign w_pr12 = {4'd0, r_pad_r};

  assign w_in_field = (w_cx12 < c_FW12) && (w_cy12 < c_FH12);
  assign w_border   = w_in_field && ((w_cy12 == 12'd0) || (w_cy12 == c_FH12 - 12'd1) ||
                                     (w_cx12 == 12'd0) || (w_cx12 == c_FW12 - 12'd1));
  assign w_paddle   = w_in_field &&
                      (((w_cx12 == c_PADL_X12) && (w_cy12 >= w_pl12) && (w_cy12 <= w_pl12 + c_SPAN12)) ||
                       ((w_cx12 == c_PADR_X12) && (w_cy12 >= w_pr12) && (w_cy12 <= w_pr12 + c_SPAN12)));
  assign w_ball     = w_in_field && (r_state != ST_IDLE) &&
                      (w_cx12 == w_bx12) && (w_cy12 == w_by12);
  assign w_fg       = w_border | w_paddle;

  // Registered pixel render.
  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_video   <= 1'b0;
      r_video_r <= 1'b0;
      r_video_g <= 1'b0;
      r_video_b <= 1'b0;
    end else begin
      r_video   <= pre_visible & (w_fg | w_ball);
      r_video_r <= pre_visible & w_ball;
      r_video_g <= pre_visible & w_fg;
      r_video_b <= pre_visible & ~(w_fg | w_ball);
    end
  end

  assign video     = r_video;
  assign video_r   = r_video_r;
  assign video_g   = r_video_g;
  assign video_b   = r_video_b;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pong_engine2p.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pong_engine2p                                             |
// | Description : Self-checking bench for pong_engine2p with a behavioural     |
// |               game model, directed match scenario and random play.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pong_engine2p;

  localparam int FW  = 66;
  localparam int FH  = 37;
  localparam int PH  = 6;
  localparam int FD  = 3;
  localparam int WIN = 2;
  localparam int PS  = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic [1:0]  key_l, key_r;
  logic        key_start_n;
  logic [7:0]  char_count;
  logic [11:0] line_count;
  logic        pre_visible;
  logic        video, video_r, video_g, video_b;
  logic [7:0]  score_l, score_r;
  logic        game_over, winner;
  logic [2:0]  state;

  always #5 clk = ~clk;

  pong_engine2p #(
    .FIELD_W(FW), .FIELD_H(FH), .CX_SHIFT(1), .CY_SHIFT(4), .PAD_H(PH),
    .FRAME_DIV(FD), .WIN_SCORE(WIN), .PAUSE_STEPS(PS)
  ) dut (
    .char_clock(clk), .reset_n(reset_n), .vsync(vsync),
    .key_l(key_l), .key_r(key_r), .key_start_n(key_start_n),
    .char_count(char_count), .line_count(line_count), .pre_visible(pre_visible),
    .video(video), .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .score_l(score_l), .score_r(score_r), .game_over(game_over),
    .winner(winner), .state(state)
  );

  // States: 0 idle, 1 serve, 2 play, 3 point, 4 game over.
  typedef struct {
    int state, bx, by, dx, dy, pl, pr, sl, sr, go, win, serve, pause;
    int frames, h1, h2, h3, start;
  } model_t;

  model_t     m;
  logic [3:0] m_vid;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         hold     = 0;
  bit         rnd_keys = 0;

  function automatic model_t f_reset();
    model_t r;
    r.state = 0; r.bx = FW / 2; r.by = FH / 2; r.dx = 1; r.dy = 1;
    r.pl = (FH - PH) / 2; r.pr = (FH - PH) / 2;
    r.sl = 0; r.sr = 0; r.go = 0; r.win = 0; r.serve = 1; r.pause = 0;
    r.frames = 0; r.h1 = 0; r.h2 = 0; r.h3 = 0; r.start = 0;
    return r;
  endfunction

  function automatic int f_pad(int top, logic up_n, logic dn_n);
    if (!up_n) return (top > 1) ? top - 1 : top;
    if (!dn_n) return (top + PH - 1 < FH - 2) ? top + 1 : top;
    return top;
  endfunction

  function automatic logic [3:0] f_render(model_t s, logic [7:0] cc, logic [11:0] lc, logic pv);
    int cx, cy;
    bit inf, brd, pad, bal;
    cx  = int'(cc) / 2;
    cy  = int'(lc) / 16;
    inf = (cx < FW) && (cy < FH);
    brd = inf && (cy == 0 || cy == FH - 1 || cx == 0 || cx == FW - 1);
    pad = inf && ((cx == 2 && cy >= s.pl && cy < s.pl + PH) ||
                  (cx == FW - 3 && cy >= s.pr && cy < s.pr + PH));
    bal = inf && s.state != 0 && cx == s.bx && cy == s.by;
    return {pv & (brd | pad | bal), pv & bal, pv & (brd | pad), pv & !(brd | pad | bal)};
  endfunction

  function automatic model_t f_next(model_t s, logic vs, logic [1:0] kl, logic [1:0] kr, logic ksn);
    model_t n;
    bit step, st;
    int ndx, ndy;
    n = s;
    step = 0;
    // vsync is seen two clocks late; the edge is a 1 sample following a 0 sample.
    if (s.h2 == 1 && s.h3 == 0) begin
      n.frames = s.frames + 1;
      step = (n.frames % FD) == 0;
    end
    n.h3 = s.h2; n.h2 = s.h1; n.h1 = int'(vs);
    st = (s.start != 0) || !ksn;
    n.start = step ? 0 : int'(st);
    if (!step) return n;
    if (s.state != 4) begin
      n.pl = f_pad(s.pl, kl[0], kl[1]);
`ifdef PONG_CPU_PLAYER_EN
      n.pr = f_pad(s.pr, !(s.pr + PH / 2 > s.by), !(s.pr + PH / 2 < s.by));
`else
      n.pr = f_pad(s.pr, kr[0], kr[1]);
`endif
    end
    case (s.state)
      0: if (st) n.state = 1;
      1: begin n.bx = FW / 2; n.by = FH / 2; n.dx = s.serve; n.dy = 1; n.state = 2; end
      2: begin
        ndx = s.dx; ndy = s.dy;
        if ((s.by == 1 && s.dy < 0) || (s.by == FH - 2 && s.dy > 0)) ndy = -s.dy;
        if (s.dx < 0 && s.bx == 3 && s.by >= s.pl && s.by < s.pl + PH) ndx = 1;
        if (s.dx > 0 && s.bx == FW - 4 && s.by >= s.pr && s.by < s.pr + PH) ndx = -1;
        n.dx = ndx; n.dy = ndy; n.bx = s.bx + ndx; n.by = s.by + ndy;
        if (n.bx == 0) begin
          n.sr = (s.sr < 255) ? s.sr + 1 : 255; n.serve = -1; n.pause = 0;
          if (n.sr == WIN) begin n.state = 4; n.go = 1; n.win = 1; end else n.state = 3;
        end else if (n.bx == FW - 1) begin
          n.sl = (s.sl < 255) ? s.sl + 1 : 255; n.serve = 1; n.pause = 0;
          if (n.sl == WIN) begin n.state = 4; n.go = 1; n.win = 0; end else n.state = 3;
        end
      end
      3: begin n.pause = s.pause + 1; if (n.pause == PS) n.state = 1; end
      default: if (st) begin n.sl = 0; n.sr = 0; n.go = 0; n.state = 1; end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m     <= f_reset();
      m_vid <= 4'b0000;
    end else begin
      m_vid <= f_render(m, char_count, line_count, pre_visible);
      m     <= f_next(m, vsync, key_l, key_r, key_start_n);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!hold) begin
      char_count  = 8'($urandom);
      line_count  = 12'($urandom_range(0, 700));
      pre_visible = 1'($urandom);
    end
    if (rnd_keys) begin
      key_l       = 2'($urandom);
      key_r       = 2'($urandom);
      key_start_n = ($urandom_range(0, 63) != 0);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    vsync = 1'b1;
    repeat (hi) tick();
    vsync = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pulses(input int n);
    repeat (n) pulse(4, 4);
  endtask

  task automatic press_start();
    key_start_n = 1'b0;
    tick();
    key_start_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; key_l = 2'b11; key_r = 2'b11; key_start_n = 1'b1;
    char_count = 8'd0; line_count = 12'd0; pre_visible = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #3;
        chk("video_rgbm", int'({video, video_r, video_g, video_b}), int'(m_vid));
        chk("state", int'(state), m.state);
        chk("score_l", int'(score_l), m.sl);
        chk("score_r", int'(score_r), m.sr);
        chk("game_over", int'(game_over), m.go);
        chk("winner", int'(winner), m.win);
      end
    join_none

    repeat (3) tick();
    chk("reset_state", int'(state), 0);
    chk("reset_scores", int'({score_l, score_r}), 0);
    chk("reset_video_r", int'(video_r), 0);
    reset_n = 1'b1;
    tick();

    press_start();
    pulses(3);
    chk("start_to_serve", int'(state), 1);
    pulses(3);
    chk("serve_to_play", int'(state), 2);
    chk("model_serve_x", m.bx, 33);
    pulses(9);
    chk("model_ball_x_after_3", m.bx, 36);
    chk("model_ball_y_after_3", m.by, 21);
    hold = 1; char_count = 8'd72; line_count = 12'd336; pre_visible = 1'b1;
    tick(); tick();
    chk("probe_ball_36_21", int'(video_r), 1);
    hold = 0;
    pulses(87);
    chk("left_scores_at_goal", int'(score_l), 1);
    chk("point_state", int'(state), 3);
    chk("right_score_zero", int'(score_r), 0);
    pulses(60);
    chk("pause_to_serve", int'(state), 1);
    pulses(3);
    chk("model_serve_dir", m.dx, 1);
    pulses(96);
    chk("game_over_flag", int'(game_over), 1);
    chk("winner_left", int'(winner), 0);
    chk("final_score_l", int'(score_l), 2);
    press_start();
    pulses(3);
    chk("restart_state", int'(state), 1);
    chk("restart_scores", int'({score_l, score_r}), 0);
    chk("restart_go", int'(game_over), 0);

    rnd_keys = 1;
    for (int i = 0; i < 3000; i++) begin
      pulse($urandom_range(1, 5), $urandom_range(2, 8));
      if (i == 1500) begin
        reset_n = 1'b0;
        tick();
        chk("midgame_reset_state", int'(state), 0);
        chk("midgame_reset_scores", int'({score_l, score_r}), 0);
        reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_engine2p.md
Name: pong_engine2p

Overview:
- Two-player successor to the single-paddle tennis game.
- Keeps the ball and paddle game state and renders the playfield to a 1-bit-per-colour video stream.
- Parametrised in field size, cell scaling, paddle height, game-step rate and winning score.
- Adds a match state machine (serve, play, point pause, game over), per-player scores and a start/restart key.
- Sits between the sync generator (char_count, line_count, pre_visible, vsync) and the VGA colour outputs.

Parameters:
- FIELD_W, 66: field width in cells; cells 0 and FIELD_W-1 are goal columns.
- FIELD_H, 37: field height in cells; rows 0 and FIELD_H-1 are walls.
- CX_SHIFT, 1: cell_x = char_count >> CX_SHIFT.
- CY_SHIFT, 4: cell_y = line_count >> CY_SHIFT.
- PAD_H, 6: paddle height in cells.
- FRAME_DIV, 3: vsync frames per game step (>=1).
- WIN_SCORE, 7: points needed to win (<=255).
- PAUSE_STEPS, 20: game steps spent in POINT before the next serve.

Ports:
- char_clock, in, 1: pixel/char clock; the only clock.
- reset_n, in, 1: asynchronous active-low reset.
- vsync, in, 1: frame sync from the sync generator; asynchronous to game logic, synchronised inside.
- key_l, in, 2: left player buttons, active low; [0]=up, [1]=down.
- key_r, in, 2: right player buttons, active low; [0]=up, [1]=down.
- key_start_n, in, 1: start/serve button, active low.
- char_count, in, 8: horizontal char position.
- line_count, in, 12: vertical line position.
- pre_visible, in, 1: active-video qualifier.
- video, out, 1: mono video.
- video_r, out, 1: red channel.
- video_g, out, 1: green channel.
- video_b, out, 1: blue channel.
- score_l, out, 8: left player score.
- score_r, out, 8: right player score.
- game_over, out, 1: high in GAMEOVER.
- winner, out, 1: winning side; 0 = left, 1 = right; valid while game_over.
- state, out, 3: FSM state encoding.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE; scores 0; game_over=0; winner=0; all video outputs 0.
  - Ball at (FIELD_W/2, FIELD_H/2), dx=+1, dy=+1.
  - Both paddles at row (FIELD_H-PAD_H)/2.
  - Step divider and vsync synchroniser cleared.
- Step tick:
  - vsync passes through a 2-flop synchroniser plus rising-edge detect.
  - A mod-FRAME_DIV counter advances on each edge; step=1 for one char_clock cycle when it wraps.
  - All game updates happen only on step cycles.
- Paddles, every step in every state except GAMEOVER:
  - Up (key[0]=0) moves top row -1, clamped at row 1.
  - Down (key[1]=0) moves +1, clamped so bottom row <= FIELD_H-2.
  - Up takes priority when both are pressed.
  - Left paddle is at column 2; right paddle at column FIELD_W-3.
  - A paddle covers rows top..top+PAD_H-1.
- FSM:
  - IDLE: ball parked at centre. key_start_n low (sampled on any cycle, latched until the next step) -> SERVE.
  - SERVE: on the next step, ball reset to centre, dy=+1, dx toward the serving side (set by POINT; +1 after reset) -> PLAY.
  - PLAY, per step, in this order:
    1. Wall bounce: if y==1 and dy=-1, or y==FIELD_H-2 and dy=+1, flip dy.
    2. Paddle hit: if dx=-1, x==3 and y is within the left paddle rows, flip dx. Mirrored on the right: dx=+1, x==FIELD_W-4, right paddle.
    3. Move the ball by the resulting dx, dy.
    - Wall and paddle flips in the same step both apply (corner rebound).
    - If the new x==0, the right player scores; if the new x==FIELD_W-1, the left player scores. Either case -> POINT.
  - POINT:
    - On entry, the scorer's score increments, saturating at 255.
    - If that score reaches WIN_SCORE -> GAMEOVER, winner=scorer, game_over=1.
    - Otherwise wait PAUSE_STEPS steps -> SERVE, with the ball served toward the side that conceded.
  - GAMEOVER: ball and paddles frozen. key_start_n low -> scores cleared, game_over=0 -> SERVE.
- Reset mid-game returns to IDLE immediately; no partial score updates survive.
- Render, registered with 1 char_clock cycle latency from char_count/line_count:
  - border = walls (rows 0 and FIELD_H-1) or goal columns.
  - paddle = either paddle cell; ball = ball cell (hidden in IDLE).
  - video_r = pre_visible & ball.
  - video_g = pre_visible & (border | paddle).
  - video_b = pre_visible & ~(border | paddle | ball).
  - video = pre_visible & (border | paddle | ball).
  - Cells outside the field render as background.

Optional Feature:
- Macro: PONG_CPU_PLAYER_EN.
- Defined:
  - key_r is ignored.
  - Each step, the right paddle moves one row toward the ball: centre row < y -> down, centre row > y -> up, equal -> hold. Same clamps as a human paddle.
- Undefined: the right paddle is driven by key_r only.

Test Plan:
- Reset with ball mid-flight, release -> state=IDLE, ball (33,18), scores 0, video_r=0 on all pixels.
- FRAME_DIV=3, 9 vsync pulses in PLAY -> exactly 3 ball moves; ball goes (33,18)->(36,21).
- Ball at (3,y), dx=-1, y within the left paddle -> next step ball at (4,y±1); score unchanged.
- Ball at (3,1), dx=-1, dy=-1, left paddle covering row 1 -> both flip; next position (4,2).
- Left paddle missing, ball reaches x=0 -> score_r 0->1; state POINT for 20 steps, then SERVE with dx=-1.
- WIN_SCORE=2, right player scores twice -> game_over=1, winner=1. Start pressed -> scores 0, state SERVE.
